swire_multi_ctrl: RTL and testbench
===================================

# swire_multi_ctrl

Multi-channel, parametrised S-wire pulse encoder for panel backlight/bias supplies. It is the successor to the single-channel fixed-timing S-wire driver. It accepts one pulse-count word per channel through a req/ack handshake and emits a shared-timing pulse train on each channel, all channels in lock-step. Each channel stops pulsing after its own count. It sits between the brightness-mapping logic and the board S-wire pins.

## Interface
- CH_NUM, 2: number of S-wire channels (≥1)
- CNT_W, 8: pulse-count width per channel
- TIME_W, 20: timer width
- INIT_TIME, 4096: high time before the first pulse, in cycles (≥1)
- PULSE_TIME, 256: duration of each low pulse and each high gap, in cycles (≥1)
- STOP_TIME, 1044228: high hold time after the last pulse, in cycles (≥1)
- i_clk_38m  in  1  system clock, 38 MHz
- i_reset_n  in  1  reset; asynchronous, active-low
- i_enable  in  1  line power enable; 0 forces all lines low and aborts any transfer
- i_req  in  1  request; held by the source until o_ack
- i_count  in  CH_NUM*CNT_W  pulse counts; channel c occupies bits [c*CNT_W +: CNT_W]
- o_ack  out  1  one-cycle pulse when the request is accepted
- o_busy  out  1  high while a transfer is in progress
- o_done  out  1  one-cycle pulse when a transfer completes normally
- o_swire  out  CH_NUM  S-wire line per channel

## Operation
- FSM states: IDLE, INIT, LOW, HIGH, STOP. One shared timer, one pulse index of CNT_W bits, latched counts, and a latched max count.
- IDLE:
  - if i_enable && i_req: latch i_count, latch max = maximum of all channel counts, clear the index, assert o_ack, go to INIT.
  - Otherwise stay in IDLE.
- INIT: after INIT_TIME cycles, go to LOW if max≠0, else go to STOP.
- LOW: lasts PULSE_TIME cycles, then go to HIGH and increment the index.
- HIGH: lasts PULSE_TIME cycles. Then go to STOP if index==max, else go to LOW.
- STOP: lasts STOP_TIME cycles, then pulse o_done and return to IDLE.
- Timer resets to 0 on every state entry. A state exits on the cycle where timer==T−1, so each state lasts exactly T cycles.
- Line value:
  - Channel c is low in LOW iff index < count[c]. Otherwise it is high.
  - All lines are high in INIT, HIGH and STOP.
  - All lines are high in IDLE when i_enable=1, and low when i_enable=0.
- A channel with count 0 stays high for the whole transfer. Channels with count < max stop pulsing early and stay high.
- i_req outside IDLE is ignored: no o_ack, no latching. A request still held is accepted once the FSM is back in IDLE.
- i_enable=0 in any state: next state is IDLE, o_busy drops, no o_done, lines go low. Latched counts are discarded.
- o_busy=1 in every state other than IDLE.

## Timing
- All outputs are registered. Reset values: o_swire=0, o_ack=0, o_busy=0, o_done=0, state IDLE, timer 0, index 0.
- Request sampled at edge k → o_ack and o_busy high after edge k+1.
- Waveform timing:
  - o_swire follows the state with 1 cycle of lag.
  - The first falling edge on o_swire comes INIT_TIME cycles after o_ack rises.
  - Each low pulse is exactly PULSE_TIME cycles; each high gap is exactly PULSE_TIME cycles.
- o_done rises on the cycle o_busy falls.
- Minimum back-to-back spacing is o_done to the next o_ack: 1 cycle, because the request must be sampled in IDLE.
- Total transfer length = INIT_TIME + 2·PULSE_TIME·max + STOP_TIME cycles.
- An asynchronous reset mid-transfer forces the reset values immediately.

## Structure
- Shared header swire_defs.vh holds:
  - the FSM state encodings, 3 bits;
  - the default timing constants shared with the legacy single-channel driver.
- Sub-module swire_pulse_timer: TIME_W loadable up-counter with a clear input and a terminal-count flag at a programmable value. Instantiated once.
- The max-count reduction and the per-channel line decode stay in the top module as generate loops.

## Test plan
- Reset: hold i_reset_n=0 → all outputs 0. Release with i_enable=1 → o_swire=all-1, o_busy=0.
- Test parameters: INIT_TIME=16, PULSE_TIME=4, STOP_TIME=8, CH_NUM=2. Request counts {ch1=1, ch0=3} → ch0 gives 3 low pulses of 4 cycles; ch1 gives 1 low pulse aligned with ch0's first; o_done fires once, 16+24+8 cycles after o_ack.
- Counts all 0 → no low pulses; o_busy high for exactly 24 cycles; o_done pulses.
- Hold i_req=1 during a busy transfer with new counts → no second o_ack until after o_done. The second transfer then uses the new counts.
- Deassert i_enable during the 2nd LOW → lines low the next cycle, o_busy=0, no o_done. Re-enable → lines high, FSM in IDLE.
- Count=255 on CNT_W=8 → exactly 255 pulses, index never wraps, o_done asserted.

Source files
------------

// File: rtl/swire_multi_ctrl_pkg.sv
// swire_multi_ctrl_pkg: FSM state encodings and default S-wire timing shared with the legacy driver
package swire_multi_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_LOW  = 3'd2,
    ST_HIGH = 3'd3,
    ST_STOP = 3'd4
  } state_t;
  localparam int DEF_INIT_TIME  = 4096;
  localparam int DEF_PULSE_TIME = 256;
  localparam int DEF_STOP_TIME  = 1044228;
endpackage

// File: rtl/swire_pulse_timer.sv
// swire_pulse_timer: loadable up-counter with clear and terminal-count flag at a programmable value
module swire_pulse_timer #(
  parameter int TIME_W = 20
) (
  input  logic              i_clk_38m,
  input  logic              i_reset_n,
  input  logic              clr,
  input  logic              load,
  input  logic [TIME_W-1:0] load_val,
  input  logic [TIME_W-1:0] term,
  output logic              tc
);
  logic [TIME_W-1:0] cnt;
  always_ff @(posedge i_clk_38m or negedge i_reset_n)
    if (!i_reset_n) cnt <= '0;
    else cnt <= clr ? '0 : load ? load_val : cnt + 1'b1;
  assign tc = cnt == term;
endmodule

// File: rtl/swire_multi_ctrl.sv
// swire_multi_ctrl: multi-channel lock-step S-wire pulse encoder with req/ack count loading
module swire_multi_ctrl
  import swire_multi_ctrl_pkg::*;
#(
  parameter int CH_NUM     = 2,
  parameter int CNT_W      = 8,
  parameter int TIME_W     = 20,
  parameter int INIT_TIME  = DEF_INIT_TIME,
  parameter int PULSE_TIME = DEF_PULSE_TIME,
  parameter int STOP_TIME  = DEF_STOP_TIME
) (
  input  logic                    i_clk_38m,
  input  logic                    i_reset_n,
  input  logic                    i_enable,
  input  logic                    i_req,
  input  logic [CH_NUM*CNT_W-1:0] i_count,
  output logic                    o_ack,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [CH_NUM-1:0]       o_swire
);
  state_t st, st_n;
  logic [CNT_W-1:0] idx, idx_n, mx, mx_n;
  logic [CH_NUM*CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] mx_in [CH_NUM+1];
  logic [TIME_W-1:0] term;
  logic [CH_NUM-1:0] line_n;
  logic tc, ack_n, done_n;
  assign mx_in[0] = '0;
  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    assign mx_in[c+1] = i_count[c*CNT_W +: CNT_W] > mx_in[c] ? i_count[c*CNT_W +: CNT_W] : mx_in[c];
    assign line_n[c]  = st_n == ST_IDLE ? i_enable : !(st_n == ST_LOW && idx_n < cnt_n[c*CNT_W +: CNT_W]);
  end
  assign term = st == ST_INIT ? TIME_W'(INIT_TIME - 1) :
                st == ST_STOP ? TIME_W'(STOP_TIME - 1) : TIME_W'(PULSE_TIME - 1);
  swire_pulse_timer #(.TIME_W(TIME_W)) u_timer (
    .i_clk_38m(i_clk_38m),
    .i_reset_n(i_reset_n),
    .clr      (st == ST_IDLE || st_n != st),
    .load     (1'b0),
    .load_val ('0),
    .term     (term),
    .tc       (tc)
  );
  always_comb begin
    st_n   = st;
    idx_n  = idx;
    mx_n   = mx;
    cnt_n  = cnt;
    ack_n  = 1'b0;
    done_n = 1'b0;
    if (!i_enable) begin
      st_n  = ST_IDLE;
      idx_n = '0;
      mx_n  = '0;
      cnt_n = '0;
    end else begin
      case (st)
        ST_IDLE: if (i_req) begin
          st_n  = ST_INIT;
          cnt_n = i_count;
          mx_n  = mx_in[CH_NUM];
          idx_n = '0;
          ack_n = 1'b1;
        end
        ST_INIT: if (tc) st_n = mx != '0 ? ST_LOW : ST_STOP;
        ST_LOW: if (tc) begin
          st_n  = ST_HIGH;
          idx_n = idx + 1'b1;
        end
        ST_HIGH: if (tc) st_n = idx == mx ? ST_STOP : ST_LOW;
        ST_STOP: if (tc) begin
          st_n   = ST_IDLE;
          done_n = 1'b1;
        end
        default: st_n = ST_IDLE;
      endcase
    end
  end
  always_ff @(posedge i_clk_38m or negedge i_reset_n)
    if (!i_reset_n) begin
      st      <= ST_IDLE;
      idx     <= '0;
      mx      <= '0;
      cnt     <= '0;
      o_ack   <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_swire <= '0;
    end else begin
      st      <= st_n;
      idx     <= idx_n;
      mx      <= mx_n;
      cnt     <= cnt_n;
      o_ack   <= ack_n;
      o_busy  <= st_n != ST_IDLE;
      o_done  <= done_n;
      o_swire <= line_n;
    end
endmodule

// File: tb/tb_swire_multi_ctrl.sv
// tb_swire_multi_ctrl: directed scoreboard bench for the lock-step S-wire encoder
module tb_swire_multi_ctrl;
  localparam int CH = 2, CW = 8, TW = 20, IT = 16, PT = 4, ST = 8;
  logic clk = 0, rst_n = 0, en = 0, req = 0;
  logic [CH*CW-1:0] cnt = '0;
  logic ack, busy, done;
  logic [CH-1:0] sw;
  int n_chk = 0, n_fail = 0;
  typedef struct {int n0; int n1; int dur; int first;} exp_t;
  exp_t sbq[$];
  always #5 clk = ~clk;
  swire_multi_ctrl #(
    .CH_NUM(CH), .CNT_W(CW), .TIME_W(TW),
    .INIT_TIME(IT), .PULSE_TIME(PT), .STOP_TIME(ST)
  ) dut (
    .i_clk_38m(clk),
    .i_reset_n(rst_n),
    .i_enable (en),
    .i_req    (req),
    .i_count  (cnt),
    .o_ack    (ack),
    .o_busy   (busy),
    .o_done   (done),
    .o_swire  (sw)
  );
  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic exp_t model(input int c0, input int c1);
    exp_t e;
    int m = c0 > c1 ? c0 : c1;
    e.n0 = c0;
    e.n1 = c1;
    e.dur = IT + 2 * PT * m + ST;
    e.first = m > 0 ? IT : -1;
    return e;
  endfunction
  task automatic drive(input int c0, input int c1, input bit push);
    cnt = {CW'(c1), CW'(c0)};
    req = 1'b1;
    if (push) sbq.push_back(model(c0, c1));
  endtask
  task automatic wait_ack(input int lim, output int w);
    w = -1;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk);
      if (ack) begin
        w = i;
        break;
      end
    end
  endtask
  task automatic watch(input int lim, output int xa, output int n0, output int n1,
                       output int bad, output int first, output int dur, output int bb);
    int run [CH];
    int nn [CH];
    logic [CH-1:0] prev;
    xa = 0; bad = 0; first = -1; dur = -1; bb = 0;
    prev = sw;
    for (int c = 0; c < CH; c++) begin
      run[c] = 0;
      nn[c] = 0;
    end
    for (int t = 1; t <= lim; t++) begin
      @(negedge clk);
      if (ack) xa++;
      for (int c = 0; c < CH; c++) begin
        if (prev[c] && !sw[c]) begin
          nn[c]++;
          if (first < 0) first = t;
        end
        if (!sw[c]) run[c]++;
        else begin
          if (!prev[c] && run[c] != PT) bad++;
          run[c] = 0;
        end
      end
      if (done) begin
        dur = t;
        if (busy) bb++;
        break;
      end else if (!busy) bb++;
      prev = sw;
    end
    n0 = nn[0];
    n1 = nn[1];
  endtask
  task automatic check_xfer(input string nm, input int lim);
    int xa, n0, n1, bad, first, dur, bb;
    exp_t e;
    watch(lim, xa, n0, n1, bad, first, dur, bb);
    e = sbq.pop_front();
    chk({nm, "_pulses_ch0"}, n0, e.n0);
    chk({nm, "_pulses_ch1"}, n1, e.n1);
    chk({nm, "_ack_to_done"}, dur, e.dur);
    chk({nm, "_first_fall"}, first, e.first);
    chk({nm, "_bad_pulse_len"}, bad, 0);
    chk({nm, "_busy_shape"}, bb, 0);
    chk({nm, "_extra_ack"}, xa, 0);
  endtask
  initial begin
    int w, dn, ak, hi;
    en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_swire", sw, 0);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_swire", sw, 3);
    chk("idle_busy", busy, 0);
    drive(3, 1, 1);
    wait_ack(5, w);
    chk("t1_ack_wait", w, 1);
    chk("t1_busy_with_ack", busy, 1);
    req = 1'b0;
    check_xfer("t1", 200);
    @(negedge clk);
    chk("t1_after_swire", sw, 3);
    drive(0, 0, 1);
    wait_ack(5, w);
    chk("t2_ack_wait", w, 1);
    req = 1'b0;
    check_xfer("t2", 200);
    drive(0, 2, 1);
    wait_ack(5, w);
    chk("t3_ack_wait", w, 1);
    drive(2, 1, 1);
    check_xfer("t3a", 200);
    wait_ack(5, w);
    chk("t3_second_ack_wait", w, 1);
    req = 1'b0;
    check_xfer("t3b", 200);
    drive(3, 3, 0);
    wait_ack(5, w);
    chk("t4_ack_wait", w, 1);
    req = 1'b0;
    repeat (25) @(negedge clk);
    chk("t4_low2_swire", sw, 0);
    chk("t4_low2_busy", busy, 1);
    en = 1'b0;
    @(negedge clk);
    chk("t4_dis_swire", sw, 0);
    chk("t4_dis_busy", busy, 0);
    dn = 0; ak = 0; hi = 0;
    repeat (40) begin
      @(negedge clk);
      dn += int'(done);
      ak += int'(ack);
      hi += int'(sw != 0 || busy);
    end
    chk("t4_no_done", dn, 0);
    chk("t4_no_ack", ak, 0);
    chk("t4_stay_low", hi, 0);
    en = 1'b1;
    @(negedge clk);
    chk("t4_reen_swire", sw, 3);
    chk("t4_reen_busy", busy, 0);
    drive(255, 0, 1);
    wait_ack(5, w);
    chk("t5_ack_wait", w, 1);
    req = 1'b0;
    check_xfer("t5", 3000);
    drive(5, 5, 0);
    wait_ack(5, w);
    chk("t6_ack_wait", w, 1);
    req = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_arst_swire", sw, 0);
    chk("t6_arst_busy", busy, 0);
    chk("t6_arst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_post_swire", sw, 3);
    chk("t6_post_busy", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
